// File: rtl/sd_match_logger.sv
// Timestamps 1001-detector match pulses into a small FIFO drained over valid/ready.
// Define MATCH_LOG_DROP_OLDEST_EN to overwrite the oldest entry on overflow instead of dropping the new one.
module sd_match_logger #(
   parameter int TS_W  = 16,
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       det_in,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [TS_W-1:0]            ev_time,
   output logic [$clog2(DEPTH):0]     ev_level,
   output logic [CNT_W-1:0]           match_count,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [TS_W-1:0]  ts_q, ts_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TS_W-1:0]  mem_q [DEPTH];
   logic [TS_W-1:0]  mem_d [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic [TS_W-1:0]  head_q, head_d;

   logic             full, pop, wr_en, drop;

   always_comb begin
      ts_d    = ts_q + TS_W'(1);
      cnt_d   = cnt_q;
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      drop    = 1'b0;

      full = (level_q == LW'(DEPTH));
      pop  = ev_ready && (level_q != '0);

      if (det_in) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (!full || pop) begin
            wr_en = 1'b1;
         end else begin
            ovf_d = 1'b1;
`ifdef MATCH_LOG_DROP_OLDEST_EN
            wr_en = 1'b1;
            drop  = 1'b1;
`else
            drop  = 1'b0;
`endif
         end
      end

      if (wr_en) begin
         mem_d[wr_q] = ts_q;
         wr_d        = wr_q + PW'(1);
      end
      if (pop || drop) begin
         rd_d = rd_q + PW'(1);
      end

      // Oldest-drop keeps the level constant: one entry in, one entry out.
      if (wr_en && !pop && !drop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !wr_en) begin
         level_d = level_q - LW'(1);
      end

      if (clr) begin
         ts_d    = '0;
         cnt_d   = '0;
         rd_d    = '0;
         wr_d    = '0;
         level_d = '0;
         ovf_d   = 1'b0;
      end

      valid_d = (level_d != '0);
      head_d  = valid_d ? mem_d[rd_d] : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q    <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         head_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ts_q    <= ts_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign ev_valid    = valid_q;
   assign ev_time     = head_q;
   assign ev_level    = level_q;
   assign match_count = cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_sd_match_logger.sv
// Directed testbench for sd_match_logger; a second instance with TS_W=4 covers timestamp wrap.
module tb_sd_match_logger;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr;
   logic        det_in;
   logic        ev_ready;
   logic        ev_valid;
   logic [15:0] ev_time;
   logic [2:0]  ev_level;
   logic [7:0]  match_count;
   logic        overflow;

   logic        ev_valid4;
   logic [3:0]  ev_time4;
   logic [2:0]  ev_level4;
   logic [7:0]  match_count4;
   logic        overflow4;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sd_match_logger #(.TS_W(16), .CNT_W(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .clr(clr), .det_in(det_in),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_time(ev_time),
      .ev_level(ev_level), .match_count(match_count), .overflow(overflow)
   );

   sd_match_logger #(.TS_W(4), .CNT_W(8), .DEPTH(4)) dut4 (
      .clk(clk), .reset(reset), .clr(clr), .det_in(det_in),
      .ev_valid(ev_valid4), .ev_ready(ev_ready), .ev_time(ev_time4),
      .ev_level(ev_level4), .match_count(match_count4), .overflow(overflow4)
   );

   task automatic tick(input logic d, input logic r, input logic c);
      det_in   = d;
      ev_ready = r;
      clr      = c;
      @(posedge clk);
      #1;
      det_in   = 1'b0;
      clr      = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; clr = 1'b0; det_in = 1'b1; ev_ready = 1'b0;
      @(posedge clk); #1;
      vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %0b want 0", ev_valid); end
      vectors++; if (ev_time !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_time got %0d want 0", ev_time); end
      vectors++; if (ev_level !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_level got %0d want 0", ev_level); end
      vectors++; if (match_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d want 0", match_count); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf got %0b want 0", overflow); end
      det_in = 1'b0;
      reset  = 1'b1;
   endtask

   task automatic test_detector_stream;
      logic [6:0]  bits = 7'b1001001;
      logic [3:0]  sr = 4'b0000;
      logic [15:0] t [2];
      int          npop = 0;
      tick(0, 1, 1);
      for (int i = 6; i >= 0; i--) begin
         sr = {sr[2:0], bits[i]};
         tick(sr == 4'b1001, 1, 0);
         if (ev_valid) begin
            if (npop < 2) t[npop] = ev_time;
            npop++;
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 0);
         if (ev_valid) begin
            if (npop < 2) t[npop] = ev_time;
            npop++;
         end
      end
      vectors++; if (npop !== 2) begin miscompares++; $display("[TB] FAIL stream_pops got %0d want 2", npop); end
      if (npop >= 2) begin
         vectors++; if (t[0] !== 16'd3) begin miscompares++; $display("[TB] FAIL stream_t0 got %0d want 3", t[0]); end
         vectors++; if (t[1] - t[0] !== 16'd3) begin miscompares++; $display("[TB] FAIL stream_delta got %0d want 3", t[1] - t[0]); end
      end
      vectors++; if (match_count !== 8'd2) begin miscompares++; $display("[TB] FAIL stream_count got %0d want 2", match_count); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_ovf got %0b want 0", overflow); end
   endtask

   task automatic test_overflow;
      logic [15:0] exp [4];
`ifdef MATCH_LOG_DROP_OLDEST_EN
      exp = '{16'd13, 16'd16, 16'd19, 16'd22};
`else
      exp = '{16'd10, 16'd13, 16'd16, 16'd19};
`endif
      tick(0, 0, 1);
      for (int ts = 0; ts <= 22; ts++) begin
         tick(ts == 10 || ts == 13 || ts == 16 || ts == 19 || ts == 22, 0, 0);
      end
      vectors++; if (ev_level !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_level got %0d want 4", ev_level); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag got %0b want 1", overflow); end
      vectors++; if (match_count !== 8'd5) begin miscompares++; $display("[TB] FAIL ovf_count got %0d want 5", match_count); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (ev_valid !== 1'b1 || ev_time !== exp[i]) begin
            miscompares++; $display("[TB] FAIL ovf_drain%0d got v=%0b t=%0d want v=1 t=%0d", i, ev_valid, ev_time, exp[i]);
         end
         tick(0, 1, 0);
      end
      vectors++; if (ev_valid !== 1'b0 || ev_time !== 16'd0 || ev_level !== 3'd0) begin
         miscompares++; $display("[TB] FAIL ovf_empty got v=%0b t=%0d l=%0d want 0/0/0", ev_valid, ev_time, ev_level);
      end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky got %0b want 1", overflow); end
   endtask

   task automatic test_full_push_pop;
      tick(0, 0, 1);
      for (int i = 0; i < 4; i++) tick(1, 0, 0);
      vectors++; if (ev_level !== 3'd4 || ev_time !== 16'd0) begin
         miscompares++; $display("[TB] FAIL fpp_fill got l=%0d t=%0d want 4/0", ev_level, ev_time);
      end
      tick(1, 1, 0);
      vectors++; if (ev_level !== 3'd4) begin miscompares++; $display("[TB] FAIL fpp_level got %0d want 4", ev_level); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL fpp_ovf got %0b want 0", overflow); end
      for (int i = 1; i <= 4; i++) begin
         vectors++; if (ev_time !== 16'(i)) begin miscompares++; $display("[TB] FAIL fpp_drain got %0d want %0d", ev_time, i); end
         tick(0, 1, 0);
      end
   endtask

   task automatic test_empty_pop;
      tick(0, 1, 1);
      tick(0, 1, 0);
      vectors++; if (ev_level !== 3'd0 || ev_valid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL empty_pop got l=%0d v=%0b want 0/0", ev_level, ev_valid);
      end
      tick(1, 1, 0);
      vectors++; if (ev_level !== 3'd1 || ev_valid !== 1'b1 || ev_time !== 16'd1) begin
         miscompares++; $display("[TB] FAIL empty_pushpop got l=%0d v=%0b t=%0d want 1/1/1", ev_level, ev_valid, ev_time);
      end
      tick(0, 0, 0);
      tick(0, 0, 0);
      vectors++; if (ev_valid !== 1'b1 || ev_time !== 16'd1) begin
         miscompares++; $display("[TB] FAIL hold_stable got v=%0b t=%0d want 1/1", ev_valid, ev_time);
      end
   endtask

   task automatic test_saturate;
      tick(0, 1, 1);
      for (int i = 0; i < 300; i++) tick(1, 1, 0);
      vectors++; if (match_count !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_count got %0d want 255", match_count); end
      vectors++; if (overflow !== 1'b0 || ev_level !== 3'd1) begin
         miscompares++; $display("[TB] FAIL sat_fifo got o=%0b l=%0d want 0/1", overflow, ev_level);
      end
      for (int i = 0; i < 5; i++) tick(1, 1, 0);
      vectors++; if (match_count !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_hold got %0d want 255", match_count); end
   endtask

   task automatic test_wrap;
      tick(0, 1, 1);
      for (int i = 0; i < 17; i++) tick(0, 0, 0);
      tick(1, 0, 0);
      vectors++; if (ev_time !== 16'd17) begin miscompares++; $display("[TB] FAIL wrap_ts16 got %0d want 17", ev_time); end
      vectors++; if (ev_time4 !== 4'd1) begin miscompares++; $display("[TB] FAIL wrap_ts4 got %0d want 1", ev_time4); end
   endtask

   task automatic test_clr;
      tick(0, 1, 1);
      for (int i = 0; i < 5; i++) tick(1, 0, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      vectors++; if (ev_level !== 3'd2 || overflow !== 1'b1) begin
         miscompares++; $display("[TB] FAIL clr_setup got l=%0d o=%0b want 2/1", ev_level, overflow);
      end
      tick(1, 1, 1);
      vectors++; if (ev_level !== 3'd0 || ev_valid !== 1'b0 || ev_time !== 16'd0) begin
         miscompares++; $display("[TB] FAIL clr_fifo got l=%0d v=%0b t=%0d want 0/0/0", ev_level, ev_valid, ev_time);
      end
      vectors++; if (match_count !== 8'd0 || overflow !== 1'b0) begin
         miscompares++; $display("[TB] FAIL clr_flags got c=%0d o=%0b want 0/0", match_count, overflow);
      end
      tick(1, 0, 0);
      vectors++; if (ev_time !== 16'd0 || ev_level !== 3'd1) begin
         miscompares++; $display("[TB] FAIL clr_ts got t=%0d l=%0d want 0/1", ev_time, ev_level);
      end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 5; i++) tick(1, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      vectors++; if (ev_valid !== 1'b0 || ev_time !== 16'd0 || ev_level !== 3'd0) begin
         miscompares++; $display("[TB] FAIL areset_fifo got v=%0b t=%0d l=%0d want 0/0/0", ev_valid, ev_time, ev_level);
      end
      vectors++; if (match_count !== 8'd0 || overflow !== 1'b0) begin
         miscompares++; $display("[TB] FAIL areset_flags got c=%0d o=%0b want 0/0", match_count, overflow);
      end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_detector_stream();
      test_overflow();
      test_full_push_pop();
      test_empty_pop();
      test_saturate();
      test_wrap();
      test_clr();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sd_match_logger.md
Name: sd_match_logger

Overview:
- Downstream consumer of the 1001 sequence detector.
- Timestamps each detection pulse against a free-running cycle counter and buffers the timestamps in a small FIFO.
- Drains the FIFO over a valid/ready interface to a host or trace unit.
- Keeps a saturating total-match count and a sticky overflow flag.

Parameters:
TS_W, 16, width of cycle counter and stored timestamp
CNT_W, 8, width of saturating match counter
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
clr  input  1  synchronous clear of counters, FIFO and flag
det_in  input  1  detector output bit 0; one cycle high = one match
ev_valid  output  1  FIFO head holds a timestamp
ev_ready  input  1  consumer accepts head this cycle
ev_time  output  TS_W  timestamp at FIFO head; 0 when empty
ev_level  output  $clog2(DEPTH)+1  current FIFO occupancy
match_count  output  CNT_W  total matches seen, saturating
overflow  output  1  sticky: a match was lost (or overwritten)

Behaviour:
- Reset (reset=0, async): ts counter=0, match_count=0, FIFO empty, ev_valid=0, ev_time=0, ev_level=0, overflow=0. Outputs are held while reset=0.
- ts counter: increments by 1 every clock, wraps 2^TS_W-1 -> 0.
- Event: any cycle where det_in=1 at the edge. Level sampled, not edge-detected. Two consecutive high cycles count as two events; the detector cannot produce this, but the logger accepts it.
- Push: on an event, the ts value in that same cycle is written (pre-increment). Example: det_in=1 in cycle where ts=5 stores 5.
- Pop: ev_valid & ev_ready at the edge; the head advances.
- Latency: an event into an empty FIFO gives ev_valid=1 one cycle later. There is no combinational bypass.
- ev_valid = (ev_level != 0). All outputs are registered.
- match_count: +1 per event, saturates at 2^CNT_W-1 and holds. It is independent of FIFO fullness.
- Full (ev_level=DEPTH), push with no pop: event dropped, FIFO unchanged, overflow <= 1. match_count still increments.
- Full, push and pop in the same cycle: both occur, level stays DEPTH, no overflow.
- Empty with ev_ready=1: no effect.
- Empty, push and pop in the same cycle: the pop is ignored (ev_valid=0); the push occurs.
- clr=1 (sync), highest priority:
  - ts<=0, match_count<=0, FIFO emptied, overflow<=0.
  - A det_in event and a pop in the clr cycle are both discarded.
- overflow: cleared only by reset or clr.
- ev_time/ev_valid: may change only after a pop or a push to empty. They are stable while ev_valid=1 and ev_ready=0.

Optional Feature:
- Macro: MATCH_LOG_DROP_OLDEST_EN
- Defined: on push into a full FIFO with no pop, the oldest entry is discarded and the new timestamp is written. Level stays DEPTH; ev_time shows the next-oldest entry. overflow <= 1.
- Undefined: the newest event is dropped, as in Behaviour.
- All other behaviour is identical.

Test Plan:
- Reset then serial stream 1001001 driven through the detector, ev_ready=1:
  - Expect det_in pulses 3 cycles apart, two pops.
  - Timestamps differ by 3.
  - match_count=2, overflow=0.
- ev_ready=0, 5 events at ts=10,13,16,19,22, DEPTH=4:
  - ev_level=4, overflow=1, match_count=5.
  - Default: drain yields 10,13,16,19.
  - With MATCH_LOG_DROP_OLDEST_EN: drain yields 13,16,19,22.
- Full FIFO, event and ev_ready=1 in the same cycle: level stays 4, overflow stays 0, head advances.
- CNT_W=8, 300 events with ev_ready=1: match_count=255 and holds.
- TS_W=4, event at cycle 17 after reset: stored timestamp=1 (wrap).
- clr=1 coincident with det_in=1 and 2 entries queued:
  - Next cycle: ev_level=0, match_count=0, overflow=0, ts=0.
  - Drive reset=0 mid-stream: all outputs 0 immediately, with no clock edge required.
